// File: rtl/map_probe_responder.sv
// map_probe_responder: answers ball move-legality probes by scanning the leading edge tiles of the world map
//   req_*  : probe handshake (ball top-left x/y, direction), req_ready high only when idle
//   rsp_*  : one-cycle verdict strobe with held move_ok / goal flags
//   map_*  : synchronous map read port, info returned one cycle after map_rd_en
module map_probe_responder #(
  parameter int BALL_SIZE  = 15,
  parameter int WORLD_W    = 640,
  parameter int WORLD_H    = 480,
  parameter int TILE_SHIFT = 2,
  parameter int MAP_ROW_W  = 7,
  parameter int MAP_COL_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [9:0]           req_x,
  input  logic [8:0]           req_y,
  input  logic [1:0]           req_dir,
  output logic                 rsp_valid,
  output logic                 rsp_move_ok,
  output logic                 rsp_goal,
  output logic                 map_rd_en,
  output logic [MAP_ROW_W-1:0] map_row_addr,
  output logic [MAP_COL_W-1:0] map_col_addr,
  input  logic [1:0]           map_loc_info
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [4:0]  K_LAST = 5'(BALL_SIZE - 1);
  localparam logic [1:0]  UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;
  state_t state_q, state_d;
  logic [9:0] x_q, x_d, sx;
  logic [8:0] y_q, y_d, sy;
  logic [1:0] dir_q, dir_d, sd;
  logic [4:0] k_q, k_d, sk;
  logic ok_q, ok_d, goal_q, goal_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic rsp_move_ok_q, rsp_move_ok_d, rsp_goal_q, rsp_goal_d, map_rd_en_q, map_rd_en_d;
  logic [MAP_ROW_W-1:0] map_row_addr_q, map_row_addr_d;
  logic [MAP_COL_W-1:0] map_col_addr_q, map_col_addr_d;
  logic accept, oob, sample;
  logic [10:0] px, py;
  always_comb begin
    accept = req_valid & req_ready_q;
    oob = (req_dir == LEFT && req_x == 10'd0) || (req_dir == UP && req_y == 9'd0) ||
          (req_dir == RIGHT && {1'b0, req_x} + BS >= 11'(WORLD_W)) ||
          (req_dir == DOWN && {2'b0, req_y} + BS >= 11'(WORLD_H));
    // info returned during ISSUE pixel k>0 and DRAIN belongs to the previous read
    sample = (state_q == ISSUE && k_q != 5'd0) || state_q == DRAIN;
    // address for the read issued next cycle: pixel 0 from the request, else pixel k+1
    sx = accept ? req_x : x_q;
    sy = accept ? req_y : y_q;
    sd = accept ? req_dir : dir_q;
    sk = accept ? 5'd0 : k_q + 5'd1;
    px = sd == RIGHT ? {1'b0, sx} + BS : sd == LEFT ? {1'b0, sx} - 11'd1 : {1'b0, sx} + {6'b0, sk};
    py = sd == DOWN ? {2'b0, sy} + BS : sd == UP ? {2'b0, sy} - 11'd1 : {2'b0, sy} + {6'b0, sk};
    state_d = state_q == IDLE  ? (accept ? (oob ? RESP : ISSUE) : IDLE) :
              state_q == ISSUE ? (k_q == K_LAST ? DRAIN : ISSUE) :
              state_q == DRAIN ? RESP : IDLE;
    k_d = state_q == ISSUE ? k_q + 5'd1 : 5'd0;
    x_d = sx;
    y_d = sy;
    dir_d = sd;
    // an out-of-bounds probe starts (and ends) with move_ok cleared
    ok_d = accept ? ~oob : ok_q & ~(sample && map_loc_info == 2'b10);
    goal_d = accept ? 1'b0 : goal_q | (sample && map_loc_info == 2'b11);
    req_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RESP;
    rsp_move_ok_d = state_d == RESP ? ok_d : rsp_move_ok_q;
    rsp_goal_d = state_d == RESP ? goal_d : rsp_goal_q;
    map_rd_en_d = state_d == ISSUE;
    map_row_addr_d = map_rd_en_d ? MAP_ROW_W'(py >> TILE_SHIFT) : map_row_addr_q;
    map_col_addr_d = map_rd_en_d ? MAP_COL_W'(px >> TILE_SHIFT) : map_col_addr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      dir_q <= '0;
      k_q <= '0;
      ok_q <= 1'b0;
      goal_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_move_ok_q <= 1'b0;
      rsp_goal_q <= 1'b0;
      map_rd_en_q <= 1'b0;
      map_row_addr_q <= '0;
      map_col_addr_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      dir_q <= dir_d;
      k_q <= k_d;
      ok_q <= ok_d;
      goal_q <= goal_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_move_ok_q <= rsp_move_ok_d;
      rsp_goal_q <= rsp_goal_d;
      map_rd_en_q <= map_rd_en_d;
      map_row_addr_q <= map_row_addr_d;
      map_col_addr_q <= map_col_addr_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_move_ok = rsp_move_ok_q;
  assign rsp_goal = rsp_goal_q;
  assign map_rd_en = map_rd_en_q;
  assign map_row_addr = map_row_addr_q;
  assign map_col_addr = map_col_addr_q;
endmodule

// File: tb/tb_map_probe_responder.sv
// tb_map_probe_responder: directed probes against a tile-array map, checked every cycle by a behavioural model
module tb_map_probe_responder;
  localparam int BS = 15;
  logic clk = 0, reset = 1, req_valid = 0;
  logic [9:0] req_x = 0;
  logic [8:0] req_y = 0;
  logic [1:0] req_dir = 0, map_loc_info;
  logic req_ready, rsp_valid, rsp_move_ok, rsp_goal, map_rd_en;
  logic [6:0] map_row_addr;
  logic [7:0] map_col_addr;
  logic [1:0] tile [0:127][0:255];
  int checks = 0, errors = 0;
  bit en = 0, tracking = 0, rst_prev = 0, e_oob, e_ok, e_goal, last_ok = 0, last_goal = 0;
  int cyc, e_lat, acc_cnt = 0, obs_lat, obs_ok, obs_goal;
  int e_row [32];
  int e_col [32];

  map_probe_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_dir(req_dir), .rsp_valid(rsp_valid),
    .rsp_move_ok(rsp_move_ok), .rsp_goal(rsp_goal), .map_rd_en(map_rd_en),
    .map_row_addr(map_row_addr), .map_col_addr(map_col_addr), .map_loc_info(map_loc_info)
  );

  always #5 clk = ~clk;

  // map memory: idle cycles return "goal" so a stray sample shows up in the verdict
  always @(posedge clk) map_loc_info <= map_rd_en ? tile[map_row_addr][map_col_addr] : 2'b11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expectation for one probe, straight from the edge/bounds rules
  task automatic model(input int x, input int y, input int d);
    int px, py, t;
    e_oob = (d == 2 && x == 0) || (d == 0 && y == 0) || (d == 3 && x + BS >= 640) || (d == 1 && y + BS >= 480);
    e_lat = e_oob ? 1 : BS + 2;
    e_ok = !e_oob;
    e_goal = 0;
    if (!e_oob)
      for (int k = 0; k < BS; k++) begin
        px = d == 3 ? x + BS : d == 2 ? x - 1 : x + k;
        py = d == 1 ? y + BS : d == 0 ? y - 1 : y + k;
        e_row[k] = py / 4;
        e_col[k] = px / 4;
        t = tile[py / 4][px / 4];
        if (t == 2) e_ok = 0;
        if (t == 3) e_goal = 1;
      end
  endtask

  always @(negedge clk) if (en) begin
    if (reset) begin
      tracking = 0;
      last_ok = 0;
      last_goal = 0;
      if (rst_prev) begin
        chk("rst_rd_en", map_rd_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 1);
      end
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      if (tracking) begin
        cyc++;
        chk("rd_en", map_rd_en, (!e_oob && cyc >= 1 && cyc <= BS) ? 1 : 0);
        if (!e_oob && cyc >= 1 && cyc <= BS) begin
          chk("row_addr", map_row_addr, e_row[cyc-1]);
          chk("col_addr", map_col_addr, e_col[cyc-1]);
        end
        chk("ready_busy", req_ready, 0);
        chk("rsp_valid", rsp_valid, cyc == e_lat ? 1 : 0);
        if (rsp_valid) begin
          obs_lat = cyc;
          obs_ok = rsp_move_ok;
          obs_goal = rsp_goal;
        end
        if (cyc == e_lat) begin
          chk("move_ok", rsp_move_ok, e_ok);
          chk("goal", rsp_goal, e_goal);
          last_ok = e_ok;
          last_goal = e_goal;
          tracking = 0;
        end
      end else begin
        chk("idle_ready", req_ready, 1);
        chk("idle_rd_en", map_rd_en, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("held_ok", rsp_move_ok, last_ok);
        chk("held_goal", rsp_goal, last_goal);
        if (req_valid) begin
          model(req_x, req_y, req_dir);
          tracking = 1;
          cyc = 0;
          acc_cnt++;
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    int a0 = acc_cnt;
    while (acc_cnt == a0 && n < 100) begin @(posedge clk); #1; n++; end
    if (acc_cnt == a0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance required one within 100 cycles");
    end
  endtask

  // inputs switch to nx/ny/nd right after acceptance; the probe in flight must ignore them
  task automatic probe(input int x, input int y, input int d, input bit hold, input int nx, input int ny, input int nd);
    int n = 0;
    obs_lat = -1;
    req_x = 10'(x);
    req_y = 9'(y);
    req_dir = 2'(d);
    req_valid = 1;
    wait_accept();
    req_x = 10'(nx);
    req_y = 9'(ny);
    req_dir = 2'(nd);
    req_valid = hold;
    while (tracking && n < 60) begin @(posedge clk); #1; n++; end
    if (tracking) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid required one within 60 cycles");
    end
  endtask

  initial begin
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 256; c++)
        tile[r][c] = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_move_ok", rsp_move_ok, 0);
    chk("reset_goal", rsp_goal, 0);
    chk("reset_rd_en", map_rd_en, 0);
    chk("reset_row", map_row_addr, 0);
    chk("reset_col", map_col_addr, 0);
    @(posedge clk); #1;
    reset = 0;
    en = 1;
    // empty map, RIGHT edge
    probe(521, 247, 3, 0, 5, 5, 0);
    chk("pin_lat17", obs_lat, 17);
    chk("pin_ok_empty", obs_ok, 1);
    chk("pin_goal_empty", obs_goal, 0);
    chk("pin_model_row0", e_row[0], 61);
    chk("pin_model_row1", e_row[1], 62);
    chk("pin_model_row14", e_row[14], 65);
    chk("pin_model_col", e_col[7], 134);
    // wall mid-edge, still full latency
    tile[63][134] = 2'b10;
    probe(521, 247, 3, 0, 0, 0, 2);
    chk("pin_wall_ok", obs_ok, 0);
    chk("pin_wall_lat", obs_lat, 17);
    // out-of-bounds and boundary cases
    probe(0, 100, 2, 0, 9, 9, 1);
    chk("pin_oob_left_lat", obs_lat, 1);
    chk("pin_oob_left_ok", obs_ok, 0);
    probe(625, 100, 3, 0, 0, 0, 0);
    chk("pin_oob_right_lat", obs_lat, 1);
    probe(624, 100, 3, 0, 0, 0, 0);
    chk("pin_edge_right_ok", obs_ok, 1);
    probe(300, 0, 0, 0, 0, 0, 0);
    probe(300, 465, 1, 0, 0, 0, 0);
    chk("pin_oob_down_lat", obs_lat, 1);
    probe(1, 1, 0, 0, 0, 0, 0);
    probe(1, 1, 2, 0, 0, 0, 0);
    // goal on DOWN edge, then wall plus goal
    tile[78][52] = 2'b11;
    probe(200, 300, 1, 0, 0, 0, 0);
    chk("pin_goal_ok", obs_ok, 1);
    chk("pin_goal_goal", obs_goal, 1);
    chk("pin_model_down_col0", e_col[0], 50);
    chk("pin_model_down_col14", e_col[14], 53);
    chk("pin_model_down_row", e_row[3], 78);
    tile[78][51] = 2'b10;
    probe(200, 300, 1, 0, 0, 0, 0);
    chk("pin_both_ok", obs_ok, 0);
    chk("pin_both_goal", obs_goal, 1);
    // reset in the middle of a scan
    req_x = 10'd100;
    req_y = 9'd100;
    req_dir = 2'b11;
    req_valid = 1;
    wait_accept();
    req_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    repeat (25) @(posedge clk);
    #1;
    probe(521, 247, 3, 0, 0, 0, 0);
    chk("pin_after_reset_ok", obs_ok, 0);
    chk("pin_after_reset_lat", obs_lat, 17);
    // back-to-back with req_valid held: wall first, clean edge second
    probe(521, 247, 3, 1, 400, 100, 1);
    chk("pin_b2b_first_ok", obs_ok, 0);
    probe(400, 100, 1, 0, 0, 0, 0);
    chk("pin_b2b_second_ok", obs_ok, 1);
    chk("pin_b2b_second_goal", obs_goal, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
